// File: rtl/riscv_defs.sv
// Shared CPU/prefetch definitions: reset vector, fetch alignment and the
// prefetch FSM state encoding, so the core and the prefetcher agree.
package riscv_defs;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h4000;
    localparam logic [15:0] FETCH_ALIGN_MASK = 16'hfffc;
    localparam int          FETCH_ENTRY_W    = 48;

    typedef enum logic {
        PF_REQUEST = 1'b0,
        PF_CAPTURE = 1'b1
    } pf_state_t;

    // Sequential word fetch; wraps modulo 2^16.
    function automatic logic [15:0] next_fetch_pc(input logic [15:0] pc);
        return pc + 16'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the prefetcher.
// Flush and reset empty it in one cycle; stored data is never cleared since
// the pointers alone decide what is visible.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage write; a discarded push is harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; reset and flush empty the queue.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: a two-state request/capture FSM that fetches one
// word every two cycles into a small FIFO, with flush redirecting the stream.
module instruction_prefetch
    import riscv_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] flush_address,
    input  logic        mem_hold,
    output logic [15:0] mem_address,
    output logic        mem_bus_enable,
    input  logic [31:0] mem_read,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    pf_state_t                r_state;
    pf_state_t                w_state_next;
    logic                     r_bus_en;
    logic                     w_bus_en_next;
    logic [15:0]              r_mem_addr;
    logic [15:0]              w_mem_addr_next;
    logic [15:0]              r_fetch_pc;
    logic [15:0]              w_fetch_pc_next;
    logic                     w_push;
    logic                     w_pop;
    logic [CNT_W-1:0]         w_count;
    logic [FETCH_ENTRY_W-1:0] w_head;

    // State, bus strobe, bus address and fetch PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PF_REQUEST;
            r_bus_en   <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_bus_en   <= w_bus_en_next;
            r_mem_addr <= w_mem_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // Next-state logic: issue when there is room, capture the response the
    // cycle after; a flush redirects and drops whatever is in flight.
    always_comb begin
        w_state_next    = r_state;
        w_bus_en_next   = 1'b0;
        w_mem_addr_next = r_mem_addr;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        if (flush) begin
            w_state_next    = PF_REQUEST;
            w_fetch_pc_next = flush_address & FETCH_ALIGN_MASK;
        end else begin
            case (r_state)
                PF_REQUEST: begin
                    // No slot is reserved for the in-flight word: with at most
                    // one outstanding request, count < DEPTH guarantees room.
                    if (!mem_hold && (w_count < FULL_COUNT)) begin
                        w_bus_en_next   = 1'b1;
                        w_mem_addr_next = r_fetch_pc;
                        w_state_next    = PF_CAPTURE;
                    end
                end
                PF_CAPTURE: begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = next_fetch_pc(r_fetch_pc);
                    w_state_next    = PF_REQUEST;
                end
                default: begin
                    w_state_next = PF_REQUEST;
                end
            endcase
        end
    end

    assign w_pop = instr_valid & instr_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fetch_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data ({r_fetch_pc, mem_read}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign mem_address    = r_mem_addr;
    assign mem_bus_enable = r_bus_en;
    assign instr_valid    = (w_count != '0);
    assign instr          = w_head[31:0];
    assign instr_pc       = w_head[47:32];

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed scenarios followed by random
// traffic, checked by a scoreboard against a stream-level reference model.
module tb_instruction_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] flush_address;
    logic        mem_hold;
    logic [15:0] mem_address;
    logic        mem_bus_enable;
    logic [31:0] mem_read;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic        model_ok = 1'b0;
    logic        exp_en   = 1'b0;
    logic [15:0] next_issue;

    instruction_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .flush_address  (flush_address),
        .mem_hold       (mem_hold),
        .mem_address    (mem_address),
        .mem_bus_enable (mem_bus_enable),
        .mem_read       (mem_read),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: word at address A is A ^ 32'hA5A50000.
    always_comb mem_read = {16'h0000, mem_address} ^ 32'hA5A50000;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: inputs are stable at the falling edge, so the
    // model decides here what the coming rising edge must do.
    always @(negedge clk) begin
        int   occ;
        logic pop;
        exp_t e;
        occ = sb.size();
        if (model_ok) begin
            check("bus_enable", {47'd0, mem_bus_enable}, {47'd0, exp_en});
            check("instr_valid", {47'd0, instr_valid}, {47'd0, (occ != 0)});
        end
        if (reset) begin
            sb.delete();
            next_issue = RESET_PC;
            exp_en     = 1'b0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            if (flush) begin
                sb.delete();
                next_issue = flush_address & 16'hfffc;
                exp_en     = 1'b0;
            end else begin
                pop = (occ != 0) && instr_ready;
                if (pop) begin
                    e = sb.pop_front();
                    check("instr_pc", {32'd0, instr_pc}, {32'd0, e.pc});
                    check("instr", {16'd0, instr}, {16'd0, e.data});
                end
                if (exp_en) begin
                    check("mem_address", {32'd0, mem_address}, {32'd0, next_issue});
                    e.pc   = next_issue;
                    e.data = {16'h0000, next_issue} ^ 32'hA5A50000;
                    sb.push_back(e);
                    next_issue = next_issue + 16'd4;
                    exp_en     = 1'b0;
                end else begin
                    exp_en = !mem_hold && (occ < DEPTH);
                end
                if (sb.size() > DEPTH) begin
                    errors++;
                    $display("FAIL occupancy got %0d limit %0d", sb.size(), DEPTH);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait until the DUT is in its bus-enable (capture) cycle.
    task automatic wait_capture(input string name);
        for (int i = 0; i < 40; i++) begin
            if (mem_bus_enable === 1'b1) return;
            cyc(1);
        end
        errors++;
        $display("FAIL %s timeout waiting for mem_bus_enable", name);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        flush_address = 16'h0000;
        mem_hold      = 1'b0;
        instr_ready   = 1'b1;
        cyc(3);

        // Cold start with a consumer always ready.
        reset = 1'b0;
        cyc(20);

        // Fill and stall, then single pops.
        instr_ready = 1'b0;
        cyc(20);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        cyc(6);
        instr_ready = 1'b1;
        cyc(10);

        // Flush during a capture cycle to an unaligned address.
        wait_capture("flush_capture");
        flush         = 1'b1;
        flush_address = 16'h1236;
        cyc(1);
        flush = 1'b0;
        cyc(12);

        // Bus hold in request state, then hold asserted during capture.
        instr_ready = 1'b0;
        flush       = 1'b1;
        flush_address = 16'h2000;
        cyc(1);
        flush    = 1'b0;
        mem_hold = 1'b1;
        cyc(5);
        mem_hold = 1'b0;
        wait_capture("hold_capture");
        mem_hold = 1'b1;
        cyc(1);
        mem_hold    = 1'b0;
        instr_ready = 1'b1;
        cyc(10);

        // Address wrap.
        flush         = 1'b1;
        flush_address = 16'hfff8;
        cyc(1);
        flush = 1'b0;
        cyc(16);

        // Flush with a pop on a full FIFO.
        instr_ready = 1'b0;
        cyc(16);
        instr_ready   = 1'b1;
        flush         = 1'b1;
        flush_address = 16'h0100;
        cyc(1);
        flush = 1'b0;
        cyc(8);

        // Reset during capture.
        wait_capture("reset_capture");
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(10);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            instr_ready   = ($urandom_range(0, 9) < 7);
            mem_hold      = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            flush_address = 16'($urandom);
            reset         = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        reset       = 1'b0;
        flush       = 1'b0;
        mem_hold    = 1'b0;
        instr_ready = 1'b1;
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
